cost_min_normalize: RTL and testbench
=====================================

COST_MIN_NORMALIZE -- requirements
Module: cost_min_normalize

Interface
REQ-001 Parameter DW, default 8: width of one aggregated cost word.
REQ-002 Parameter NDISP, default 64: disparities per pixel, range 2..128.
REQ-003 clk  input  1: single clock; all state updates on posedge clk.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 s_valid  input  1: upstream cost word valid.
REQ-006 s_ready  output  1: block accepts a cost word this cycle.
REQ-007 s_data  input  DW: aggregated cost for the current disparity, unsigned.
REQ-008 s_last  input  1: upstream marks the final disparity of a pixel.
REQ-009 m_valid  output  1: normalized cost word valid.
REQ-010 m_ready  input  1: downstream accepts the word.
REQ-011 m_data  output  DW: cost minus pixel minimum, unsigned.
REQ-012 m_last  output  1: final normalized word of a pixel.
REQ-013 m_min  output  DW: minimum cost of the pixel being drained.
REQ-014 err  output  1: sticky framing error flag.

Function
REQ-015 Two states, FILL and DRAIN; reset enters FILL.
REQ-016 FILL: s_ready=1, m_valid=0; each s_valid&s_ready handshake writes s_data to buf[wr_idx], increments wr_idx, and updates min_reg.
REQ-017 min_reg update: first word of a pixel loads s_data; later words load min(min_reg, s_data); on ties the stored value is unchanged.
REQ-018 Pixel ends on the handshake with wr_idx==NDISP-1; next cycle the state is DRAIN, wr_idx=0, rd_idx=0.
REQ-019 s_last is checked only on accepted words: s_last=1 with wr_idx!=NDISP-1, or s_last=0 with wr_idx==NDISP-1, sets err=1; the pixel boundary still follows REQ-018.
REQ-020 err stays 1 until rst.
REQ-021 DRAIN: s_ready=0, m_valid=1, m_data=buf[rd_idx]-min_reg, m_min=min_reg, m_last=(rd_idx==NDISP-1).
REQ-022 The subtraction saturates at 0; m_data never wraps, even if buffer contents are corrupt.
REQ-023 m_data, m_last and m_min hold stable while m_valid=1 and m_ready=0.
REQ-024 On m_valid&m_ready, rd_idx increments; on the handshake with m_last=1, the state returns to FILL the next cycle with rd_idx=0.
REQ-025 Latency: the first m_valid is asserted the cycle after the final input handshake of a pixel.
REQ-026 The first s_ready after a drain is the cycle after the m_last handshake.
REQ-027 No input is accepted during DRAIN; no overlap exists between pixels.
REQ-028 Throughput is one word per cycle per phase, giving 2*NDISP cycles per pixel with no backpressure.
REQ-029 Indices are ceil(log2(NDISP)) bits wide and never exceed NDISP-1.

Reset
REQ-030 When rst=1 at a posedge, the next state is FILL with wr_idx=0, rd_idx=0, min_reg=all-ones, and err=0.
REQ-031 Outputs after reset: s_ready=1, m_valid=0, m_data=0, m_last=0, m_min=all-ones.
REQ-032 A reset mid-FILL or mid-DRAIN discards the partial pixel; no further m_valid is asserted for it.
REQ-033 Buffer contents are not reset; they are never visible before being rewritten.

Verification (NDISP=4, DW=8)
REQ-034 Input 10,3,7,3 with s_last on the 4th word, m_ready=1 -> m_data 7,0,4,0; m_min=3; m_last on the 4th output only; m_valid rises 1 cycle after the 4th input; err=0.
REQ-035 Input 255,255,255,255 -> m_data 0,0,0,0 and m_min=255; then input 0,255,128,1 -> m_data 0,255,128,1 and m_min=0.
REQ-036 With m_ready toggled 1,0,0,1,... during a drain -> m_data holds across stall cycles; no word is lost or duplicated; s_ready stays 0 until the cycle after the m_last handshake.
REQ-037 s_last on the 2nd word of a pixel -> err=1 immediately after that handshake; the pixel still drains 4 words; err persists across following good pixels until rst.
REQ-038 rst pulsed for one cycle after 2 words of a pixel -> s_ready=1, m_valid=0, m_min=255; the next 4-word pixel 5,6,7,8 -> m_data 0,1,2,3.
REQ-039 Back-to-back pixels with s_valid held at 1 -> exactly 4 accepts, then 4 outputs, repeated, with every output equal to the reference model.

Source files
------------

// File: rtl/cost_min_normalize.sv
// Buffers one pixel's NDISP aggregated costs, then replays each cost minus the pixel minimum.
// Latency: first output the cycle after the final input; no input/output overlap between pixels.
module cost_min_normalize #(
    parameter int DW    = 8,
    parameter int NDISP = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic [DW-1:0] m_min,
    output logic          err
);

    localparam int            IW       = (NDISP > 1) ? $clog2(NDISP) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDISP - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [DW-1:0] min_q, min_d;
    logic          err_q, err_d;

    // Cost storage is never reset: every slot is rewritten before it is read.
    logic [DW-1:0] cost_mem_q [NDISP];

    logic          s_fire;
    logic          m_fire;
    logic          wr_at_last;
    logic          rd_at_last;
    logic [DW-1:0] rd_word;

    always_comb begin
        s_ready    = (state_q == FILL);
        m_valid    = (state_q == DRAIN);
        s_fire     = s_valid && s_ready;
        m_fire     = m_valid && m_ready;
        wr_at_last = (wr_idx_q == LAST_IDX);
        rd_at_last = (rd_idx_q == LAST_IDX);
        rd_word    = cost_mem_q[rd_idx_q];
    end

    // Saturating subtract keeps m_data sane even if a stored word is below the minimum.
    always_comb begin
        m_data = '0;
        m_last = 1'b0;
        if (state_q == DRAIN) begin
            m_last = rd_at_last;
            if (rd_word > min_q) begin
                m_data = rd_word - min_q;
            end
        end
        m_min = min_q;
        err   = err_q;
    end

    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        min_d    = min_q;
        err_d    = err_q;
        case (state_q)
            FILL: begin
                if (s_fire) begin
                    if ((wr_idx_q == '0) || (s_data < min_q)) begin
                        min_d = s_data;
                    end
                    // Framing is checked but never overrides the word count.
                    if (s_last != wr_at_last) begin
                        err_d = 1'b1;
                    end
                    if (wr_at_last) begin
                        wr_idx_d = '0;
                        rd_idx_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (m_fire) begin
                    if (rd_at_last) begin
                        rd_idx_d = '0;
                        state_d  = FILL;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            min_q    <= '1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            min_q    <= min_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (s_fire) begin
            cost_mem_q[wr_idx_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_cost_min_normalize.sv
// Directed bench for cost_min_normalize at NDISP=4, DW=8 with hand-computed expectations.
module tb_cost_min_normalize;

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic [7:0] m_min;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    logic exp_err = 1'b0;

    cost_min_normalize #(.DW(8), .NDISP(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_min   (m_min),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] norm(input logic [7:0] v, input logic [7:0] mn);
        return (v >= mn) ? (v - mn) : 8'd0;
    endfunction

    // Feeds four words; called and returning at 1 time unit after a rising edge.
    task automatic feed4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input int last_pos, input bit keep_valid);
        logic [7:0] w [4];
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        for (int i = 0; i < 4; i++) begin
            chk("fill_s_ready", s_ready, 1);
            chk("fill_m_valid", m_valid, 0);
            s_valid = 1'b1;
            s_data  = w[i];
            s_last  = (i == last_pos);
            @(posedge clk); #1;
            if ((i == last_pos) != (i == 3)) exp_err = 1'b1;
            chk("err_after_accept", err, exp_err);
        end
        if (keep_valid) begin
            s_data = 8'hEE;
            s_last = 1'b1;
        end else begin
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
        chk("m_valid_latency", m_valid, 1);
        chk("s_ready_in_drain", s_ready, 0);
    endtask

    task automatic drain4(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                          input logic [7:0] e3, input logic [7:0] mn, input bit stall);
        logic [7:0] e [4];
        int k;
        int cyc;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        k   = 0;
        cyc = 0;
        while (k < 4 && cyc < 40) begin
            chk("drain_m_valid", m_valid, 1);
            chk("drain_m_data", m_data, e[k]);
            chk("drain_m_last", m_last, (k == 3));
            chk("drain_m_min", m_min, mn);
            chk("drain_s_ready", s_ready, 0);
            m_ready = stall ? ((cyc % 3) == 0) : 1'b1;
            @(posedge clk); #1;
            if (m_ready) k++;
            cyc++;
        end
        if (k < 4) chk("drain_timeout", k, 4);
        m_ready = 1'b0;
        chk("post_drain_s_ready", s_ready, 1);
        chk("post_drain_m_valid", m_valid, 0);
        chk("post_drain_err", err, exp_err);
    endtask

    initial begin
        logic [7:0] px [3][4];
        logic [7:0] mn;

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'd0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_min", m_min, 8'd255);
        chk("rst_err", err, 0);
        rst = 1'b0;

        // Basic pixel: min 3.
        feed4(8'd10, 8'd3, 8'd7, 8'd3, 3, 1'b0);
        chk("basic_err", err, 0);
        drain4(8'd7, 8'd0, 8'd4, 8'd0, 8'd3, 1'b0);

        // All-max pixel, then a pixel spanning the full range.
        feed4(8'd255, 8'd255, 8'd255, 8'd255, 3, 1'b0);
        drain4(8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 1'b0);
        feed4(8'd0, 8'd255, 8'd128, 8'd1, 3, 1'b0);
        drain4(8'd0, 8'd255, 8'd128, 8'd1, 8'd0, 1'b0);

        // Backpressure during drain.
        feed4(8'd20, 8'd50, 8'd20, 8'd90, 3, 1'b0);
        drain4(8'd0, 8'd30, 8'd0, 8'd70, 8'd20, 1'b1);

        // Back-to-back pixels with s_valid never dropped.
        px[0][0] = 8'd100; px[0][1] = 8'd40;  px[0][2] = 8'd60; px[0][3] = 8'd40;
        px[1][0] = 8'd0;   px[1][1] = 8'd0;   px[1][2] = 8'd0;  px[1][3] = 8'd0;
        px[2][0] = 8'd77;  px[2][1] = 8'd200; px[2][2] = 8'd13; px[2][3] = 8'd14;
        for (int p = 0; p < 3; p++) begin
            mn = px[p][0];
            for (int i = 1; i < 4; i++) if (px[p][i] < mn) mn = px[p][i];
            feed4(px[p][0], px[p][1], px[p][2], px[p][3], 3, (p != 2));
            drain4(norm(px[p][0], mn), norm(px[p][1], mn), norm(px[p][2], mn),
                   norm(px[p][3], mn), mn, 1'b0);
        end

        // Early s_last: err sets after 2nd word, pixel still drains 4 words, err sticks.
        feed4(8'd4, 8'd9, 8'd2, 8'd6, 1, 1'b0);
        drain4(8'd2, 8'd7, 8'd0, 8'd4, 8'd2, 1'b0);
        feed4(8'd1, 8'd2, 8'd3, 8'd4, 3, 1'b0);
        drain4(8'd0, 8'd1, 8'd2, 8'd3, 8'd1, 1'b0);
        chk("err_sticky", err, 1);

        // Reset after two words of a pixel.
        s_valid = 1'b1; s_data = 8'd9; s_last = 1'b0;
        @(posedge clk); #1;
        s_data = 8'd2;
        @(posedge clk); #1;
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_err = 1'b0;
        chk("midfill_rst_s_ready", s_ready, 1);
        chk("midfill_rst_m_valid", m_valid, 0);
        chk("midfill_rst_m_min", m_min, 8'd255);
        chk("midfill_rst_err", err, 0);
        feed4(8'd5, 8'd6, 8'd7, 8'd8, 3, 1'b0);
        drain4(8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 1'b0);

        // Reset after one drained word: the rest of that pixel never appears.
        feed4(8'd1, 8'd1, 8'd1, 8'd1, 3, 1'b0);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        chk("middrain_still_valid", m_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ready = 1'b1;
        chk("middrain_rst_m_valid", m_valid, 0);
        chk("middrain_rst_s_ready", s_ready, 1);
        @(posedge clk); #1;
        chk("middrain_rst_m_valid_later", m_valid, 0);
        m_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
